// File: rtl/trace_record_parser_if.sv
// rtl/trace_record_parser_if.sv - trace byte stream in, LRU record handshake out
interface trace_record_parser_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        eof;
   logic        consumer_idle;
   logic [16:0] LRUTag;
   logic [10:0] LRUIndex;
   logic        LRULoadStore;
   logic [20:0] LRUInst;
   logic        LRULineReady;

   modport master (
      output byte_in, byte_valid, eof, consumer_idle,
      input  byte_ready, LRUTag, LRUIndex, LRULoadStore, LRUInst, LRULineReady
   );

   modport slave (
      input  byte_in, byte_valid, eof, consumer_idle,
      output byte_ready, LRUTag, LRUIndex, LRULoadStore, LRUInst, LRULineReady
   );
endinterface

// File: rtl/trace_record_parser.sv
// rtl/trace_record_parser.sv - parses ASCII load/store trace lines into LRU records
module trace_record_parser (
   input  logic                 clk,
   input  logic                 rst,
   trace_record_parser_if.slave bus,
   output logic [15:0]          error_count,
   output logic                 done
);
   typedef enum logic [2:0] {
      ST_OP, ST_SEP, ST_ADDR, ST_TRAIL, ST_SKIP, ST_EMIT, ST_DONE
   } state_t;

   state_t      state, state_n;
   logic        op, op_n;
   logic [31:0] acc, acc_n;
   logic [3:0]  cnt, cnt_n;
   logic        sep_seen, sep_n;
   logic        eof_pending, eofp_n;
   logic        armed;
   logic [20:0] rec_cnt;
   logic        xfer, eof_ev, err, accept, load_rec;
   logic        is_blank, is_cr, is_lf, is_op, is_store, is_hex;
   logic [3:0]  nib;

   // {valid, value} of an ASCII hex digit, either case
   function automatic logic [4:0] hex_decode(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39)
         r = {1'b1, c[3:0]};
      else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
         r = {1'b1, c[3:0] + 4'd9};
      return r;
   endfunction

   // character classes of the byte currently offered
   always_comb begin
      is_blank        = (bus.byte_in == 8'h20) || (bus.byte_in == 8'h09);
      is_cr           = (bus.byte_in == 8'h0D);
      is_lf           = (bus.byte_in == 8'h0A);
      is_store        = (bus.byte_in == 8'h53) || (bus.byte_in == 8'h73);
      is_op           = is_store || (bus.byte_in == 8'h4C) || (bus.byte_in == 8'h6C);
      {is_hex, nib}   = hex_decode(bus.byte_in);
   end

   // line grammar: next state, accumulator updates, error and acceptance strobes
   always_comb begin
      state_n  = state;
      op_n     = op;
      acc_n    = acc;
      cnt_n    = cnt;
      sep_n    = sep_seen;
      eofp_n   = eof_pending;
      err      = 1'b0;
      accept   = 1'b0;
      xfer     = bus.byte_valid & bus.byte_ready;
      eof_ev   = bus.eof & ~xfer;
      case (state)
         ST_OP: begin
            if (xfer) begin
               if (is_op) begin
                  op_n    = is_store;
                  acc_n   = 32'd0;
                  cnt_n   = 4'd0;
                  sep_n   = 1'b0;
                  state_n = ST_SEP;
               end else if (!(is_blank || is_cr || is_lf)) begin
                  err     = 1'b1;
                  state_n = ST_SKIP;
               end
            end else if (eof_ev) begin
               state_n = ST_DONE;
            end
         end
         ST_SEP: begin
            if (xfer) begin
               if (is_blank) begin
                  sep_n = 1'b1;
               end else if (is_hex && sep_seen) begin
                  acc_n   = {28'd0, nib};
                  cnt_n   = 4'd1;
                  state_n = ST_ADDR;
               end else begin
                  err     = 1'b1;
                  state_n = is_lf ? ST_OP : ST_SKIP;
               end
            end else if (eof_ev) begin
               err     = 1'b1;
               state_n = ST_DONE;
            end
         end
         ST_ADDR: begin
            if (xfer) begin
               if (is_hex) begin
                  if (cnt == 4'd8) begin
                     err     = 1'b1;
                     state_n = ST_SKIP;
                  end else begin
                     acc_n = {acc[27:0], nib};
                     cnt_n = cnt + 4'd1;
                  end
               end else if (is_blank || is_cr) begin
                  state_n = ST_TRAIL;
               end else if (is_lf) begin
                  state_n = ST_EMIT;
               end else begin
                  err     = 1'b1;
                  state_n = ST_SKIP;
               end
            end else if (eof_ev) begin
               eofp_n  = 1'b1;
               state_n = ST_EMIT;
            end
         end
         ST_TRAIL: begin
            if (xfer) begin
               if (is_lf) begin
                  state_n = ST_EMIT;
               end else if (!(is_blank || is_cr)) begin
                  err     = 1'b1;
                  state_n = ST_SKIP;
               end
            end else if (eof_ev) begin
               eofp_n  = 1'b1;
               state_n = ST_EMIT;
            end
         end
         ST_SKIP: begin
            if (xfer && is_lf)
               state_n = ST_OP;
            else if (eof_ev)
               state_n = ST_DONE;
         end
         ST_EMIT: begin
            if (bus.LRULineReady && bus.consumer_idle && armed) begin
               accept  = 1'b1;
               eofp_n  = 1'b0;
               state_n = eof_pending ? ST_DONE : ST_OP;
            end
         end
         ST_DONE: state_n = ST_DONE;
         default: state_n = ST_OP;
      endcase
      load_rec = (state_n == ST_EMIT) && (state != ST_EMIT);
   end

   // state, parse context, record outputs and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_OP;
         op               <= 1'b0;
         acc              <= 32'd0;
         cnt              <= 4'd0;
         sep_seen         <= 1'b0;
         eof_pending      <= 1'b0;
         armed            <= 1'b1;
         rec_cnt          <= 21'd0;
         error_count      <= 16'd0;
         done             <= 1'b0;
         bus.byte_ready   <= 1'b0;
         bus.LRUTag       <= 17'd0;
         bus.LRUIndex     <= 11'd0;
         bus.LRULoadStore <= 1'b0;
         bus.LRUInst      <= 21'd0;
         bus.LRULineReady <= 1'b0;
      end else begin
         state          <= state_n;
         op             <= op_n;
         acc            <= acc_n;
         cnt            <= cnt_n;
         sep_seen       <= sep_n;
         eof_pending    <= eofp_n;
         done           <= (state_n == ST_DONE);
         bus.byte_ready <= (state_n != ST_EMIT) && (state_n != ST_DONE);
         if (err && error_count != 16'hFFFF)
            error_count <= error_count + 16'd1;
         // a busy consumer re-arms the handshake so one idle window takes one record
         if (!bus.consumer_idle)
            armed <= 1'b1;
         else if (accept)
            armed <= 1'b0;
         if (load_rec) begin
            bus.LRUTag       <= acc_n[31:15];
            bus.LRUIndex     <= acc_n[14:4];
            bus.LRULoadStore <= op_n;
            bus.LRUInst      <= rec_cnt;
            bus.LRULineReady <= 1'b1;
         end else if (accept) begin
            bus.LRULineReady <= 1'b0;
            rec_cnt          <= rec_cnt + 21'd1;
         end
      end
   end
endmodule

// File: tb/tb_trace_record_parser.sv
// tb/tb_trace_record_parser.sv - scoreboard bench for trace_record_parser
module tb_trace_record_parser;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] error_count;
   logic        done;

   trace_record_parser_if bus();

   trace_record_parser dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .error_count (error_count),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [16:0] tag;
      logic [10:0] idx;
      logic        ls;
      logic [20:0] inst;
   } rec_t;

   rec_t exp_q[$];
   rec_t cur;
   int   total = 0;
   int   bad = 0;
   int   accepts = 0;
   int   cons_busy = 0;
   int   n_acc;
   logic cons_prev = 1'b0;
   logic mon_prev = 1'b0;
   logic manual = 1'b0;
   logic man_idle = 1'b0;
   logic auto_idle = 1'b1;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   always @* bus.consumer_idle = manual ? man_idle : auto_idle;

   // consumer model: busy for two cycles after each record it takes
   always @(negedge clk) begin
      if (cons_prev && !bus.LRULineReady)
         cons_busy = 2;
      else if (cons_busy > 0)
         cons_busy--;
      auto_idle = (cons_busy == 0);
      cons_prev = bus.LRULineReady;
   end

   // monitor: pop on each new record, then hold fields stable while presented
   always @(negedge clk) begin
      rec_t got;
      got = {bus.LRUTag, bus.LRUIndex, bus.LRULoadStore, bus.LRUInst};
      if (bus.LRULineReady && !mon_prev) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_record: got %0h want none", got);
         end else begin
            cur = exp_q.pop_front();
            check("record", got, cur);
         end
      end else if (bus.LRULineReady) begin
         check("record_stable", got, cur);
      end
      if (mon_prev && !bus.LRULineReady && !rst)
         accepts++;
      mon_prev = bus.LRULineReady;
   end

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      while (!bus.byte_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         total++;
         bad++;
         $display("FAIL byte_ready_timeout: got 0 want 1");
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_str(input string s, input bit emit);
      for (int i = 0; i < s.len(); i++)
         send_byte(s[i]);
      if (emit)
         check("emit_latency", bus.LRULineReady, 1);
   endtask

   task automatic wait_accept();
      int t = 0;
      while (bus.LRULineReady && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("accept_timeout", bus.LRULineReady, 0);
   endtask

   task automatic check_zero(input string name);
      check(name, {bus.LRUTag, bus.LRUIndex, bus.LRULoadStore, bus.LRUInst,
                   bus.LRULineReady, error_count, done, bus.byte_ready}, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      bus.eof        = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset_outputs");
      rst = 1'b0;
      @(negedge clk);
      check("byte_ready_after_reset", bus.byte_ready, 1);

      // load and store records with the consumer taking them promptly
      exp_q.push_back({17'h02469, 11'h2BC, 1'b0, 21'd0});
      send_str("L 1234ABCD\n", 1);
      wait_accept();
      exp_q.push_back({17'h00001, 11'h001, 1'b1, 21'd1});
      send_str(" s\t00008010\r\n", 1);
      wait_accept();

      // consumer busy: record must be held with input stalled
      manual   = 1'b1;
      man_idle = 1'b0;
      exp_q.push_back({17'h00000, 11'h0AB, 1'b0, 21'd2});
      send_str("l 00000abc\n", 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_ready", {bus.LRULineReady, bus.byte_ready}, 2'b10);
      end
      n_acc    = accepts;
      man_idle = 1'b1;
      repeat (3) @(negedge clk);
      check("single_accept", accepts - n_acc, 1);
      check("ready_dropped", bus.LRULineReady, 0);

      // idle never dropped since the last acceptance: not armed yet
      exp_q.push_back({17'h00000, 11'h001, 1'b1, 21'd3});
      send_str("S 10\n", 1);
      repeat (5) @(negedge clk);
      check("unarmed_hold", bus.LRULineReady, 1);
      man_idle = 1'b0;
      @(negedge clk);
      man_idle = 1'b1;
      wait_accept();
      manual = 1'b0;

      // malformed lines are counted and produce no record
      check("no_errors_yet", error_count, 0);
      exp_q.push_back({17'h00000, 11'h000, 1'b0, 21'd4});
      send_str("X 10\n", 0);
      send_str("L10\n", 0);
      send_str("L 123456789\n", 0);
      send_str("L 0\n", 1);
      wait_accept();
      check("error_count", error_count, 3);

      // end of stream acts as the final LF
      exp_q.push_back({17'h1FFFF, 11'h7FF, 1'b1, 21'd5});
      send_str("S FFFFFFFF", 0);
      bus.eof = 1'b1;
      for (int t = 0; t < 100 && !done; t++)
         @(negedge clk);
      check("done", done, 1);
      check("byte_ready_in_done", bus.byte_ready, 0);
      check("no_record_in_done", bus.LRULineReady, 0);
      check("queue_empty_eof", exp_q.size(), 0);

      // reset from DONE and in the middle of a line
      rst     = 1'b1;
      bus.eof = 1'b0;
      #1;
      check_zero("reset_after_done");
      @(negedge clk);
      rst = 1'b0;
      send_str("L 12", 0);
      rst = 1'b1;
      #1;
      check_zero("reset_mid_parse");
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back({17'h00000, 11'h002, 1'b0, 21'd0});
      send_str("L 20\n", 1);
      wait_accept();
      check("errors_after_reset", error_count, 0);
      check("queue_empty_end", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
